// File: rtl/pcie_mem_arbiter.sv
// rtl/pcie_mem_arbiter.sv - two-requester round-robin arbiter for the BAR memory port
// Grants whole bursts and routes each response to its issuer through an in-order owner FIFO.
module pcie_mem_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_req0_mem_valid,
    output logic        o_req0_mem_ready,
    input  logic        i_req0_mem_64,
    input  logic        i_req0_mem_write,
    input  logic [9:0]  i_req0_mem_bytes,
    input  logic [12:0] i_req0_mem_addr,
    input  logic [7:0]  i_req0_mem_strob,
    input  logic [63:0] i_req0_mem_data,
    input  logic        i_req0_mem_last,
    output logic [63:0] o_resp0_mem_data,
    output logic        o_resp0_mem_valid,
    output logic        o_resp0_mem_fault,
    input  logic        i_resp0_mem_ready,

    input  logic        i_req1_mem_valid,
    output logic        o_req1_mem_ready,
    input  logic        i_req1_mem_64,
    input  logic        i_req1_mem_write,
    input  logic [9:0]  i_req1_mem_bytes,
    input  logic [12:0] i_req1_mem_addr,
    input  logic [7:0]  i_req1_mem_strob,
    input  logic [63:0] i_req1_mem_data,
    input  logic        i_req1_mem_last,
    output logic [63:0] o_resp1_mem_data,
    output logic        o_resp1_mem_valid,
    output logic        o_resp1_mem_fault,
    input  logic        i_resp1_mem_ready,

    input  logic        i_req_mem_ready,
    output logic        o_req_mem_valid,
    output logic        o_req_mem_64,
    output logic        o_req_mem_write,
    output logic [9:0]  o_req_mem_bytes,
    output logic [12:0] o_req_mem_addr,
    output logic [7:0]  o_req_mem_strob,
    output logic [63:0] o_req_mem_data,
    output logic        o_req_mem_last,

    input  logic [63:0] i_resp_mem_data,
    input  logic        i_resp_mem_valid,
    input  logic        i_resp_mem_fault,
    output logic        o_resp_mem_ready,

    output logic        o_err_unexpected
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t          state;
    logic            last_winner;
    logic            owner_fifo [OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic full;
    logic empty;
    logic head;
    logic push;
    logic pop;
    logic pick;

    assign full  = (count == CW'(OUTSTANDING));
    assign empty = (count == '0);
    assign head  = owner_fifo[rd_ptr];
    // On a tie the requester that did not win last time gets the port.
    assign pick  = (i_req0_mem_valid && i_req1_mem_valid) ? ~last_winner : i_req1_mem_valid;

    always_comb begin
        o_req_mem_valid  = 1'b0;
        o_req_mem_64     = 1'b0;
        o_req_mem_write  = 1'b0;
        o_req_mem_bytes  = '0;
        o_req_mem_addr   = '0;
        o_req_mem_strob  = '0;
        o_req_mem_data   = '0;
        o_req_mem_last   = 1'b0;
        o_req0_mem_ready = 1'b0;
        o_req1_mem_ready = 1'b0;
        case (state)
            GRANT0: begin
                o_req_mem_valid  = i_req0_mem_valid & ~full;
                o_req0_mem_ready = i_req_mem_ready & ~full;
                o_req_mem_64     = i_req0_mem_64;
                o_req_mem_write  = i_req0_mem_write;
                o_req_mem_bytes  = i_req0_mem_bytes;
                o_req_mem_addr   = i_req0_mem_addr;
                o_req_mem_strob  = i_req0_mem_strob;
                o_req_mem_data   = i_req0_mem_data;
                o_req_mem_last   = i_req0_mem_last;
            end
            GRANT1: begin
                o_req_mem_valid  = i_req1_mem_valid & ~full;
                o_req1_mem_ready = i_req_mem_ready & ~full;
                o_req_mem_64     = i_req1_mem_64;
                o_req_mem_write  = i_req1_mem_write;
                o_req_mem_bytes  = i_req1_mem_bytes;
                o_req_mem_addr   = i_req1_mem_addr;
                o_req_mem_strob  = i_req1_mem_strob;
                o_req_mem_data   = i_req1_mem_data;
                o_req_mem_last   = i_req1_mem_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_resp0_mem_valid = 1'b0;
        o_resp0_mem_data  = '0;
        o_resp0_mem_fault = 1'b0;
        o_resp1_mem_valid = 1'b0;
        o_resp1_mem_data  = '0;
        o_resp1_mem_fault = 1'b0;
        o_resp_mem_ready  = 1'b1;
        // With nothing outstanding, responses are swallowed and flagged.
        if (!empty) begin
            if (head) begin
                o_resp1_mem_valid = i_resp_mem_valid;
                o_resp1_mem_data  = i_resp_mem_data;
                o_resp1_mem_fault = i_resp_mem_fault;
                o_resp_mem_ready  = i_resp1_mem_ready;
            end else begin
                o_resp0_mem_valid = i_resp_mem_valid;
                o_resp0_mem_data  = i_resp_mem_data;
                o_resp0_mem_fault = i_resp_mem_fault;
                o_resp_mem_ready  = i_resp0_mem_ready;
            end
        end
    end

    assign push = o_req_mem_valid & i_req_mem_ready;
    assign pop  = ~empty & i_resp_mem_valid & o_resp_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            last_winner      <= 1'b1;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            o_err_unexpected <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((i_req0_mem_valid || i_req1_mem_valid) && !full) begin
                        last_winner <= pick;
                        state       <= pick ? GRANT1 : GRANT0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (push && o_req_mem_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                owner_fifo[wr_ptr] <= (state == GRANT1);
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (empty && i_resp_mem_valid)
                o_err_unexpected <= 1'b1;
        end
    end
endmodule

// File: doc/pcie_mem_arbiter.md
# pcie_mem_arbiter

Two-requester arbiter sharing the single PCIe-side memory request/response port. Requester 0 is the PCIe I/O endpoint TLP engine. Requester 1 is a local DMA/host requester. The block sits between both requesters and the 13-bit BAR memory, grants the port round-robin with burst locking, and routes each response back to the requester that issued the matching beat, using an in-order owner FIFO.

## Interface
- `OUTSTANDING`, default 4: maximum accepted-but-unanswered beats (owner FIFO depth, power of 2, ≥2).
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `i_rst` in 1: reset is synchronous and active-high.
- `i_reqN_mem_valid` in 1 (N=0,1): request beat valid.
- `o_reqN_mem_ready` out 1: beat accepted when valid&ready.
- `i_reqN_mem_64` in 1: 0=32-bit, 1=64-bit access.
- `i_reqN_mem_write` in 1: 0=read, 1=write.
- `i_reqN_mem_bytes` in 10: burst length in bytes; 0 means 1024.
- `i_reqN_mem_addr` in 13: byte address.
- `i_reqN_mem_strob` in 8: write byte enables.
- `i_reqN_mem_data` in 64: write data.
- `i_reqN_mem_last` in 1: last beat of the burst.
- `o_respN_mem_data` out 64: routed read data.
- `o_respN_mem_valid` out 1: routed response valid.
- `o_respN_mem_fault` out 1: routed fault.
- `i_respN_mem_ready` in 1: requester accepts the response.
- `i_req_mem_ready` in 1: memory accepts a beat.
- `o_req_mem_valid`, `o_req_mem_64`, `o_req_mem_write`, `o_req_mem_bytes[9:0]`, `o_req_mem_addr[12:0]`, `o_req_mem_strob[7:0]`, `o_req_mem_data[63:0]`, `o_req_mem_last`, all out: muxed request from the granted requester.
- `i_resp_mem_data[63:0]`, `i_resp_mem_valid`, `i_resp_mem_fault`, all in: memory response, one per accepted beat.
- `o_resp_mem_ready` out 1: ready toward memory.
- `o_err_unexpected` out 1: sticky flag; a response arrived while the owner FIFO was empty.

## Operation
- State machine with states IDLE, GRANT0 and GRANT1. The state is registered.
- **IDLE.** If any `i_reqN_mem_valid` is high and the owner FIFO is not full, grant one requester:
  - Pick the requester not equal to `last_winner` when both are valid; otherwise pick the single valid one.
  - Update `last_winner` to the granted requester.
  - Move to GRANTN.
- **GRANTN.** Port-side outputs follow requester N combinationally.
  - `o_req_mem_valid` = `i_reqN_mem_valid` & FIFO not full.
  - `o_reqN_mem_ready` = `i_req_mem_ready` & FIFO not full.
  - The other requester's ready is 0.
- **Beat accept.** Every accepted beat (`o_req_mem_valid` & `i_req_mem_ready`) pushes N into the owner FIFO.
  - An accepted beat with last=1 returns the state to IDLE.
  - A burst is never interrupted by the other requester.
- **Response routing.** When the FIFO is non-empty with head H:
  - `o_respH_mem_valid` = `i_resp_mem_valid`.
  - `o_respH` data and fault = the memory response data and fault.
  - `o_resp_mem_ready` = `i_respH_mem_ready`.
  - The non-head `o_resp*_valid` is 0.
  - Pop the FIFO on `i_resp_mem_valid` & `o_resp_mem_ready`.
- **Response with FIFO empty.** `o_resp_mem_ready`=1, the response is dropped, and `o_err_unexpected` is set. It clears only on reset.
- **Outputs in IDLE.** All `o_req_mem_*` are 0 and both `o_reqN_mem_ready` are 0.
- **FIFO bookkeeping.** Count width is clog2(`OUTSTANDING`)+1. Read/write pointers wrap modulo `OUTSTANDING`. A push and pop in the same cycle leave the count unchanged. A push when full cannot occur because ready is gated.

## Timing
- **Reset values.**
  - state=IDLE, `last_winner`=1 (so requester 0 wins the first tie), FIFO empty, `o_err_unexpected`=0.
  - All `o_*` are 0 except `o_resp_mem_ready`, which is 1 while the FIFO is empty.
- **Arbitration latency.** 1 cycle: valid seen in IDLE at cycle T, beat can be accepted at T+1.
- **Between bursts.** At least 1 idle cycle after the last beat is accepted; back-to-back bursts therefore take ≥1 bubble.
- **Combinational paths.** Request path, ready path and response path are all combinational, with 0-cycle latency.
- **Simultaneous push and pop.** Both are applied; the head entry routes correctly in the same cycle.
- **Reset mid-burst or with outstanding responses.** Grant is dropped and the FIFO is cleared. Any later responses count as unexpected.
- **Requester obligation.** A requester must hold valid and payload stable until ready; the arbiter does not buffer payload.

## Test plan
- **Single read.** Only req0: 1 beat, addr=0x010, bytes=8, last=1, memory ready=1.
  - Required: accepted the cycle after valid.
  - Response data 0xDEADBEEF_00000001 appears on `resp0` only; FIFO count returns to 0.
- **Simultaneous requests after reset.** Both valid with 1-beat bursts.
  - Required: grant order is req0, req1, req0, req1, with one idle cycle between grants.
- **Burst lock.** req1 issues a 4-beat write burst; req0 asserts valid at beat 2.
  - Required: req0 is not granted until req1's last beat is accepted, then req0 is granted 1 cycle later.
- **Full FIFO.** `OUTSTANDING`=4, memory holds responses back, req0 issues 6 beats.
  - Required: 4 beats accepted, then `o_req0_mem_ready`=0.
  - After one response pops, the 5th beat is accepted.
- **Interleaved response routing.** req0 beat, req1 beat, req0 beat outstanding; responses return with fault=0, 1, 0.
  - Required: `resp0`, `resp1`, `resp0` respectively, each carrying its fault bit.
  - `i_resp1_mem_ready`=0 stalls `o_resp_mem_ready`.
- **Unexpected response and mid-burst reset.**
  - A response with the FIFO empty sets `o_err_unexpected`=1 and the response is consumed.
  - `i_rst` asserted mid-burst returns state to IDLE and clears `o_err_unexpected` and the FIFO on the next edge.
